mips_reg_file: RTL and testbench
================================

# mips_reg_file

General-purpose register file for the single-cycle MIPS datapath: 32 registers of 32 bits, two combinational read ports feeding the ALU operands and one synchronous write port driven from the write-back stage. Register 0 is the architectural `$zero`: it always reads 0 and ignores writes. The file sits between instruction decode (which supplies rs/rt/rd addresses) and write-back.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; register count is `2**ADDR_W`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high; clears every register on a rising `clk` edge.
- `r_addr1`  input  ADDR_W  read port 1 address (rs).
- `r_addr2`  input  ADDR_W  read port 2 address (rt).
- `r_data1`  output  DATA_W  contents of register `r_addr1`.
- `r_data2`  output  DATA_W  contents of register `r_addr2`.
- `w_addr`  input  ADDR_W  write address (rd/rt).
- `write_en`  input  1  write strobe, active-high.
- `w_data`  input  DATA_W  write data.

## Operation
- Storage: array of `2**ADDR_W` registers, each `DATA_W` bits wide.
- Reset: when `reset`=1 at a rising edge, all registers become 0. Reset has priority over a simultaneous write, and the write is discarded.
- Write: when `reset`=0 and `write_en`=1 at a rising edge, `reg[w_addr] <= w_data`, unless `w_addr`=0.
- `$zero`: register 0 is never written. `r_data*` is 0 whenever `r_addr*`=0, regardless of history.
- Reads: purely combinational; `r_data1`/`r_data2` follow their addresses and the current register contents with no clock.
- Both read ports are independent. The same address on both ports returns identical data.
- `write_en`=0: no register changes.
- X/undriven addresses or data are not sanitised. Behaviour with X inputs is undefined, except that reset still clears the array.

## Timing
- Write latency: data is visible on read ports immediately after the capturing rising edge. In the same cycle, before the edge, reads return the old value, unless `WRITE_BYPASS_EN` is defined.
- Read latency: zero cycles (combinational path addr → data).
- Reset is a synchronous reset, not an asynchronous one. Before the first reset edge, contents are undefined, except that register 0 reads 0.
- Back-to-back writes to the same address on consecutive edges: the last write wins.
- Reset asserted mid-sequence: on the reset edge, all contents are cleared. Writes resume on the first edge with `reset`=0.

## Configuration
- `MIPS_REG_FILE_WRITE_BYPASS_EN` defined: write-to-read forwarding is enabled. If `write_en`=1, `reset`=0, `w_addr`≠0 and `r_addrN`=`w_addr`, then `r_dataN` = `w_data` combinationally in the same cycle.
- `MIPS_REG_FILE_WRITE_BYPASS_EN` undefined: there is no forwarding, and reads return stored contents only. This is the default for the single-cycle core.
- A write to register 0 is never forwarded in either configuration.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_ADDR_W`=5, `WORD_W`=32, `ZERO_REG`=5'd0;
  - the typedefs `reg_addr_t` and `word_t`, reused by decode and write-back.
- One natural sub-module: `mips_reg_file_rd_port`, instantiated twice. It contains the read mux, the `$zero` masking and the optional bypass, and takes the array, the read address and the write-port signals.

## Test plan
- Reset: assert `reset` for one edge after random writes → all 32 registers read 0 on both ports.
- Basic write/read:
  - write 30 to r1, then 40 to r1 on the next edge;
  - set `r_addr1`=1 → reads 30 after the first edge and 40 after the second;
  - `r_addr2`=2 → 0.
- `$zero`: write 20 to r0 with `write_en`=1 → `r_data1` with `r_addr1`=0 stays 0.
- Write disable: `write_en`=0, `w_addr`=5, `w_data`=0xDEADBEEF, one edge → r5 is unchanged (0 after reset).
- Reset vs write: `reset`=1 and `write_en`=1, `w_addr`=3, `w_data`=7 on the same edge → r3 reads 0.
- Same-cycle read of the register being written (`w_addr`=`r_addr1`=4, `w_data`=0x55):
  - before the edge, with bypass off → `r_data1` reads the old value;
  - with bypass on → `r_data1` reads 0x55;
  - after the edge, in both configurations → `r_data1` reads 0x55.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and widths, reused by decode, register file and write-back.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [WORD_W-1:0]     word_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/mips_reg_file_rd_port.sv
// One combinational read port of the MIPS register file: array mux, $zero masking, and
// optional same-cycle write forwarding when MIPS_REG_FILE_WRITE_BYPASS_EN is defined.
module mips_reg_file_rd_port
    import mips_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]                  r_addr_i,
    input  logic                               reset_i,
    input  logic                               write_en_i,
    input  logic [ADDR_W-1:0]                  w_addr_i,
    input  logic [DATA_W-1:0]                  w_data_i,
    output logic [DATA_W-1:0]                  r_data_o
);

    logic rd_zero;
    assign rd_zero = (r_addr_i == ADDR_W'(ZERO_REG));

`ifdef MIPS_REG_FILE_WRITE_BYPASS_EN
    logic fwd_hit;
    // $zero is excluded by requiring a non-zero read address, which also blocks forwarding of r0 writes.
    assign fwd_hit = write_en_i && !reset_i && !rd_zero && (r_addr_i == w_addr_i);

    always_comb begin
        r_data_o = regs_i[r_addr_i];
        if (rd_zero) begin
            r_data_o = '0;
        end else if (fwd_hit) begin
            r_data_o = w_data_i;
        end
    end
`else
    logic unused_wr_port;
    assign unused_wr_port = ^{reset_i, write_en_i, w_addr_i, w_data_i};

    always_comb begin
        r_data_o = regs_i[r_addr_i];
        if (rd_zero) begin
            r_data_o = '0;
        end
    end
`endif

endmodule

// File: rtl/mips_reg_file.sv
// 32x32 MIPS register file: two combinational read ports, one synchronous write port, r0 hardwired to 0.
// Define MIPS_REG_FILE_WRITE_BYPASS_EN to forward the in-flight write to matching read ports.
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] r_addr1,
    input  logic [ADDR_W-1:0] r_addr2,
    output logic [DATA_W-1:0] r_data1,
    output logic [DATA_W-1:0] r_data2,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic              write_en,
    input  logic [DATA_W-1:0] w_data
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic                        wr_en_d;

    // Entry 0 is never written; the read ports mask it, so its storage only ever holds reset state.
    assign wr_en_d = write_en && (w_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else if (wr_en_d) begin
            regs_q[w_addr] <= w_data;
        end
    end

    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;

    assign rd_addr = {r_addr2, r_addr1};
    assign r_data1 = rd_data[0];
    assign r_data2 = rd_data[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
        mips_reg_file_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .regs_i     (regs_q),
            .r_addr_i   (rd_addr[gi]),
            .reset_i    (reset),
            .write_en_i (write_en),
            .w_addr_i   (w_addr),
            .w_data_i   (w_data),
            .r_data_o   (rd_data[gi])
        );
    end

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed bench for mips_reg_file: expected read values are queued as stimulus is driven
// and popped when the read ports are sampled.
module tb_mips_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  r_addr1;
    logic [4:0]  r_addr2;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    logic [4:0]  w_addr;
    logic        write_en;
    logic [31:0] w_data;

    mips_reg_file dut (
        .clk      (clk),
        .reset    (reset),
        .r_addr1  (r_addr1),
        .r_addr2  (r_addr2),
        .r_data1  (r_data1),
        .r_data2  (r_data2),
        .w_addr   (w_addr),
        .write_en (write_en),
        .w_data   (w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[32];
    int          checks   = 0;
    int          failures = 0;

`ifdef MIPS_REG_FILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        e.tag = tag;
        e.d1  = d1;
        e.d2  = d2;
        sb.push_back(e);
    endtask

    // Drive the read addresses, let them settle, then pop one expectation and compare both ports.
    task automatic read_chk(input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        r_addr1 = a1;
        r_addr2 = a2;
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty got=%0d required=1", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("rd %s a1=%0d a2=%0d d1=%h d2=%h", e.tag, a1, a2, r_data1, r_data2);
            checks++;
            assert (r_data1 === e.d1) else begin
                failures++;
                $error("FAIL %s_p1 got=%h required=%h", e.tag, r_data1, e.d1);
            end
            checks++;
            assert (r_data2 === e.d2) else begin
                failures++;
                $error("FAIL %s_p2 got=%h required=%h", e.tag, r_data2, e.d2);
            end
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        w_addr   = a;
        w_data   = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        if (!reset && a != 5'd0) model[a] = d;
    endtask

    initial begin
        reset    = 1'b0;
        write_en = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        r_addr1  = '0;
        r_addr2  = '0;

        // r0 reads 0 even before any reset
        push("pre_reset_r0", 32'h0, 32'h0);
        read_chk(5'd0, 5'd0);

        for (int i = 1; i < 32; i++) begin
            wr(5'(i), $urandom());
        end
        for (int i = 1; i < 32; i++) begin
            push("rand_wr", model[i], model[32 - i]);
            read_chk(5'(i), 5'(32 - i));
        end

        // Reset with a simultaneous write to r3: reset wins, the write is discarded
        reset    = 1'b1;
        write_en = 1'b1;
        w_addr   = 5'd3;
        w_data   = 32'd7;
        tick();
        reset    = 1'b0;
        write_en = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            push("reset_clear", 32'h0, 32'h0);
            read_chk(5'(i), 5'(31 - i));
        end
        push("reset_vs_wr_r3", 32'h0, 32'h0);
        read_chk(5'd3, 5'd3);

        wr(5'd1, 32'd30);
        push("wr_r1_30", 32'd30, 32'h0);
        read_chk(5'd1, 5'd2);
        wr(5'd1, 32'd40);
        push("wr_r1_40", 32'd40, 32'h0);
        read_chk(5'd1, 5'd2);

        wr(5'd0, 32'd20);
        push("zero_wr", 32'h0, 32'd40);
        read_chk(5'd0, 5'd1);

        // write_en low: no register changes
        write_en = 1'b0;
        w_addr   = 5'd5;
        w_data   = 32'hDEADBEEF;
        tick();
        push("wr_disable_r5", 32'h0, 32'd40);
        read_chk(5'd5, 5'd1);

        // Same-cycle read of the register being written
        write_en = 1'b1;
        w_addr   = 5'd4;
        w_data   = 32'h55;
        push("same_cycle_pre", BYPASS ? 32'h55 : model[4], 32'd40);
        read_chk(5'd4, 5'd1);
        tick();
        write_en = 1'b0;
        model[4] = 32'h55;
        push("same_cycle_post", 32'h55, 32'h55);
        read_chk(5'd4, 5'd4);

        // A write aimed at r0 is never forwarded
        write_en = 1'b1;
        w_addr   = 5'd0;
        w_data   = 32'h99;
        push("zero_no_fwd", 32'h0, 32'h55);
        read_chk(5'd0, 5'd4);
        tick();
        write_en = 1'b0;

        // Back-to-back writes, last wins; port 2 checks an untouched neighbour
        wr(5'd6, 32'h1111_0000);
        wr(5'd6, 32'h2222_0000);
        push("b2b_last_wins", 32'h2222_0000, 32'h55);
        read_chk(5'd6, 5'd4);

        // Mid-sequence reset, then writes resume on the first edge with reset low
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        wr(5'd7, 32'hCAFE_F00D);
        push("post_reset_wr", 32'hCAFE_F00D, 32'h0);
        read_chk(5'd7, 5'd6);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover got=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
